// File: rtl/rca_word_sequencer.sv
// rtl/rca_word_sequencer.sv - WIDTH-bit add/sub sequenced over one SLICE-bit ripple-carry slice
// Processes one slice per clock from LSB to MSB; carry between slices is held in r_carry.
module rca_word_sequencer #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  input  logic             sub,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_cout,
  output logic             res_ovf,
  output logic             busy
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NSLICE - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic             w_accept;
  logic             w_last;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [IW-1:0]    r_idx;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  logic [SLICE-1:0] w_sa;
  logic [SLICE-1:0] w_sb;
  logic [SLICE-1:0] w_ss;
  logic [SLICE-1:0] w_p;
  logic [SLICE-1:0] w_g1;
  logic [SLICE-1:0] w_g2;
  logic [SLICE:0]   w_c;
  logic             w_cmsb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_last   = 1'b0;
    case (r_state)
      S_IDLE: if (start_valid) begin
        w_accept = 1'b1;
        w_next   = S_RUN;
      end
      S_RUN: if (r_idx == LAST_IDX) begin
        w_last = 1'b1;
        w_next = S_DONE;
      end
      S_DONE: if (res_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Ripple slice: each full adder is two half adders plus an OR of their carries.
  assign w_sa   = r_a[r_idx*SLICE +: SLICE];
  assign w_sb   = r_b[r_idx*SLICE +: SLICE];
  assign w_c[0] = r_carry;

  for (genvar gi = 0; gi < SLICE; gi++) begin : g_fa
    assign w_p[gi]    = w_sa[gi] ^ w_sb[gi];
    assign w_g1[gi]   = w_sa[gi] & w_sb[gi];
    assign w_ss[gi]   = w_p[gi] ^ w_c[gi];
    assign w_g2[gi]   = w_p[gi] & w_c[gi];
    assign w_c[gi+1]  = w_g1[gi] | w_g2[gi];
  end

  assign w_cmsb = w_ss[SLICE-1] ^ w_sa[SLICE-1] ^ w_sb[SLICE-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a     <= op_a;
      r_b     <= sub ? ~op_b : op_b;
      r_carry <= sub | cin;
      r_idx   <= '0;
    end else if (r_state == S_RUN) begin
      r_sum[r_idx*SLICE +: SLICE] <= w_ss;
      r_carry <= w_c[SLICE];
      r_idx   <= w_last ? '0 : r_idx + IW'(1);
      if (w_last) begin
        r_cout <= w_c[SLICE];
        r_ovf  <= w_cmsb ^ w_c[SLICE];
      end
    end
  end

  assign start_ready = (r_state == S_IDLE);
  assign res_valid   = (r_state == S_DONE);
  assign busy        = (r_state != S_IDLE);
  assign res_sum     = r_sum;
  assign res_cout    = r_cout;
  assign res_ovf     = r_ovf;

endmodule
